// File: rtl/hour_disp_pkg.sv
// Shared constants and types for the hour display back-end.
package hour_disp_pkg;

  // Active-high 7-segment codes, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Largest legal hour count from the upstream mod-12 counter.
  localparam logic [3:0] HOUR_MAX = 4'd11;

  // One-hot digit enables driven onto the board.
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  // Which digit the scanner is currently driving.
  typedef enum logic {
    DIGIT_ONES = 1'b0,
    DIGIT_TENS = 1'b1
  } digit_e;

endpackage

// File: rtl/hour_disp_mux_seg7_enc.sv
// Combinational BCD to 7-segment encoder; non-decimal inputs show blank.
module seg7_enc
  import hour_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Decode one BCD digit to its segment pattern.
  always_comb begin
    // NOTE: every output of an always_comb gets a value on every path, here via the default arm, so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hour_disp_mux.sv
// Hour display back-end: samples the mod-12 hour count, tracks AM/PM on the
// natural 11->0 wrap, and scans two active-high 7-segment digits.
// Optional feature: define HOUR_DISP_PM_DOT_EN to light the ones-digit
// decimal point while in the PM half of the day.
module hour_disp_mux
  import hour_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          PM_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hour_in,
  input  logic       load_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_sel,
  output logic       pm,
  output logic       hour_err
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       hour_q;
  logic [CNT_W-1:0] scan_cnt;
  digit_e           digit;

  logic             hour_ok;
  logic             wrap;
  logic             scan_last;
  logic [3:0]       disp;
  logic             tens;
  logic [3:0]       ones;
  logic [6:0]       ones_code;
  logic [6:0]       seg_next;

  assign hour_ok   = (hour_in <= HOUR_MAX);
  // A forced load of 0 after 11 is not the passage of noon/midnight.
  assign wrap      = (hour_q == HOUR_MAX) && (hour_in == 4'd0) && !load_in;
  assign scan_last = (scan_cnt == CNT_LAST);

  // Map the stored count to 12-hour form and split into digits.
  always_comb begin
    disp = (hour_q == 4'd0) ? 4'd12 : hour_q;
    tens = (disp >= 4'd10);
    ones = tens ? (disp - 4'd10) : disp;
  end

  seg7_enc u_ones_enc (
    .bcd (ones),
    .seg (ones_code)
  );

  // Select the pattern for whichever digit the scanner points at; tens is 1 or blank.
  always_comb begin
    seg_next = SEG_BLANK;
    if (digit == DIGIT_ONES) begin
      seg_next = ones_code;
    end else if (tens) begin
      seg_next = SEG_1;
    end
  end

  // Sample the hour count, flag illegal values and toggle AM/PM on a true wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q   <= 4'd0;
      hour_err <= 1'b0;
      pm       <= PM_RESET;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values of the others.
      hour_err <= !hour_ok;
      if (hour_ok) begin
        hour_q <= hour_in;
      end
      if (wrap) begin
        pm <= !pm;
      end
    end
  end

  // Scan counter: stay on each digit for SCAN_DIV cycles, then flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= DIGIT_ONES;
    end else if (scan_last) begin
      scan_cnt <= '0;
      digit    <= (digit == DIGIT_ONES) ? DIGIT_TENS : DIGIT_ONES;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Register segments and digit enable together so they never disagree for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_BLANK;
      dig_sel <= DIG_ONES;
    end else begin
      seg     <= seg_next;
      dig_sel <= (digit == DIGIT_ONES) ? DIG_ONES : DIG_TENS;
    end
  end

`ifdef HOUR_DISP_PM_DOT_EN
  // PM indicator on the ones-digit decimal point, registered alongside seg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp <= 1'b0;
    end else begin
      dp <= pm && (digit == DIGIT_ONES);
    end
  end
`else
  assign dp = 1'b0;
`endif

endmodule

// File: doc/hour_disp_mux.md
# hour_disp_mux

Display back-end for the mod-12 hour counter. Samples the 4-bit hour count (0..11) every clock and maps it to 12-hour form (count 0 shown as 12). Tracks AM/PM by detecting the natural 11→0 wrap, and time-multiplexes two active-high 7-segment digits. Sits directly downstream of the hour counter and drives the board's display pins.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled; legal range ≥2.
- PM_RESET, 0: value of `pm` after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hour_in  in  4  hour count from upstream counter, legal 0..11.
- load_in  in  1  same-cycle copy of the upstream counter's load control; marks a forced value, not a wrap.
- seg  out  7  segments, active-high; bit0=a … bit6=g.
- dp  out  1  decimal point, active-high.
- dig_sel  out  2  one-hot digit enable; 2'b01 = ones, 2'b10 = tens.
- pm  out  1  1 = PM half of day.
- hour_err  out  1  registered flag: last sample was >11.

## Operation
- `hour_q` register (reset 0) captures `hour_in` each cycle when `hour_in` ≤ 11.
  - When `hour_in` > 11, `hour_q` holds and `hour_err` is set to 1 for that cycle.
  - `hour_err` is 0 otherwise.
- Wrap detect: `hour_q`==11 and `hour_in`==0 and `load_in`==0 → toggle `pm` on that edge.
  - `load_in`=1 never toggles `pm`, whatever the values.
  - 11→11 holds do not toggle.
  - 0→0 holds do not toggle.
- Display value `disp` = 12 when `hour_q`==0, else `hour_q`. Range is 1..12.
  - tens = (`disp` ≥ 10).
  - ones = `disp` − 10·tens.
- Scan counter counts 0..SCAN_DIV−1, then wraps to 0. At each wrap, the digit index flips between ones and tens.
- Ones digit selected: seg = 7-seg code of ones.
- Tens digit selected:
  - tens=1 → seg = code of 1 (7'h06).
  - tens=0 → seg = 7'h00 (leading blank).
- Segment codes 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Timing
- Reset values:
  - seg = 7'h00, dp = 0, dig_sel = 2'b01.
  - pm = PM_RESET, hour_err = 0.
  - `hour_q` = 0, scan count = 0, digit index = ones.
- `hour_in` sampled at edge N: `hour_q`, `pm` and `hour_err` update at edge N.
- `seg`, `dp` and `dig_sel` are registered. They reflect edge-N state at edge N+1, so display latency is 2 edges from `hour_in`.
- The first cycle after reset shows "2" on the ones digit: seg=7'h5B from edge 1.
- `dig_sel` changes exactly every SCAN_DIV cycles. `dig_sel` and `seg` change on the same edge, so there is no ghost cycle.
- Simultaneous wrap and digit flip: both take effect; no priority interaction.

## Configuration
- `HOUR_DISP_PM_DOT_EN` defined:
  - `dp` = `pm` while the ones digit is selected.
  - `dp` = 0 while the tens digit is selected.
  - `dp` is registered like `seg`.
- Macro not defined: `dp` is tied to 0, and no PM logic feeds it. `pm` still operates.

## Structure
- Shared package `hour_disp_pkg`:
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK.
  - HOUR_MAX = 4'd11.
  - digit-select constants DIG_ONES = 2'b01, DIG_TENS = 2'b10.
- One sub-module, `seg7_enc`: combinational 4-bit BCD → 7-segment encoder. Inputs >9 give SEG_BLANK.
- Top level holds the sample register, wrap/PM logic, scan counter and output registers.

## Test plan
- Reset with rst_n=0, hour_in=0, then release → pm=0, dig_sel=01, seg=00 during reset; seg=5B ("2") after edge 1; tens blank when selected.
- hour_in=11, then next cycle hour_in=0 with load_in=0 → pm toggles 0→1 on the second edge; display reads "12".
- Same 11→0 sequence with load_in=1 on the second cycle → pm unchanged.
- hour_in=13 for one cycle after hour_in=5 → hour_err=1 for one cycle; display stays "5"; no pm change.
- SCAN_DIV=4 with hour_in=10 → dig_sel alternates 01/10 every 4 cycles; seg alternates 3F/06 aligned with dig_sel.
- With HOUR_DISP_PM_DOT_EN and pm=1 → dp=1 only while dig_sel=01; without the macro, dp stays 0 throughout.
